// File: rtl/mem_ctrl_if.sv
// Request/response bundle between the instruction/data requesters and mem_ctrl.
// The requester side drives the master modport; the controller uses the slave modport.
interface mem_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  i_read;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_busy;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [1:0]            d_len;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_busy;
  logic                  d_ready;
  logic [DATA_WIDTH-1:0] d_rdata;

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_len, d_wdata,
    input  i_busy, i_ready, i_data, d_busy, d_ready, d_rdata
  );

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_len, d_wdata,
    output i_busy, i_ready, i_data, d_busy, d_ready, d_rdata
  );
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates the I and D requesters onto one byte-wide synchronous RAM, splitting each
// access into 1-4 byte cycles and assembling little-endian words.
module mem_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_ctrl_if.slave             bus,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  output logic [7:0]            mem_dout,
  input  logic [7:0]            mem_din
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                state_q, state_d;
  logic                  is_d_q, is_d_d;
  logic [1:0]            len_q, len_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rbuf_q, rbuf_d;
  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
  logic                  mem_wr_q, mem_wr_d;
  logic [7:0]            mem_dout_q, mem_dout_d;
  logic                  busy_q, busy_d;
  logic                  i_ready_q, i_ready_d;
  logic                  d_ready_q, d_ready_d;
  logic [DATA_WIDTH-1:0] i_data_q, i_data_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic [1:0]            byte_idx;

  // cnt_q is the index of the upcoming clock edge counted from the acceptance edge.
  // RAM read data lags the address by two edges, so byte k lands on edge k+2.
  always_comb begin
    state_d    = state_q;
    is_d_d     = is_d_q;
    len_d      = len_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    rbuf_d     = rbuf_q;
    mem_a_d    = mem_a_q;
    mem_wr_d   = 1'b0;
    mem_dout_d = mem_dout_q;
    i_ready_d  = 1'b0;
    d_ready_d  = 1'b0;
    i_data_d   = i_data_q;
    d_rdata_d  = d_rdata_q;
    byte_idx   = 2'(cnt_q - 3'd2);

    unique case (state_q)
      IDLE: begin
        if (bus.d_write || bus.d_read || bus.i_read) begin
          is_d_d  = bus.d_write || bus.d_read;
          addr_d  = is_d_d ? bus.d_addr : bus.i_addr;
          len_d   = is_d_d ? bus.d_len : 2'd3;
          wdata_d = bus.d_wdata;
          cnt_d   = 3'd1;
          rbuf_d  = '0;
          mem_a_d = addr_d;
          state_d = bus.d_write ? WRITE : READ;
          if (bus.d_write) begin
            mem_wr_d   = 1'b1;
            mem_dout_d = bus.d_wdata[7:0];
          end
        end
      end
      READ: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q <= {1'b0, len_q})
          mem_a_d = addr_q + ADDR_WIDTH'(cnt_q);
        if (cnt_q >= 3'd2)
          rbuf_d[{byte_idx, 3'b000} +: 8] = mem_din;
        if (cnt_q == {1'b0, len_q} + 3'd2) begin
          state_d = DONE;
          if (is_d_q) begin
            d_ready_d = 1'b1;
            d_rdata_d = rbuf_d;
          end else begin
            i_ready_d = 1'b1;
            i_data_d  = rbuf_d;
          end
        end
      end
      WRITE: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q <= {1'b0, len_q}) begin
          mem_a_d    = addr_q + ADDR_WIDTH'(cnt_q);
          mem_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
          mem_wr_d   = 1'b1;
        end else begin
          state_d   = DONE;
          d_ready_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      is_d_q     <= 1'b0;
      len_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      rbuf_q     <= '0;
      mem_a_q    <= '0;
      mem_wr_q   <= 1'b0;
      mem_dout_q <= '0;
      busy_q     <= 1'b0;
      i_ready_q  <= 1'b0;
      d_ready_q  <= 1'b0;
      i_data_q   <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      is_d_q     <= is_d_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      rbuf_q     <= rbuf_d;
      mem_a_q    <= mem_a_d;
      mem_wr_q   <= mem_wr_d;
      mem_dout_q <= mem_dout_d;
      busy_q     <= busy_d;
      i_ready_q  <= i_ready_d;
      d_ready_q  <= d_ready_d;
      i_data_q   <= i_data_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign bus.i_busy  = busy_q;
  assign bus.d_busy  = busy_q;
  assign bus.i_ready = i_ready_q;
  assign bus.d_ready = d_ready_q;
  assign bus.i_data  = i_data_q;
  assign bus.d_rdata = d_rdata_q;
  assign mem_a       = mem_a_q;
  assign mem_wr      = mem_wr_q;
  assign mem_dout    = mem_dout_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized bench for mem_ctrl: a byte RAM model serves the DUT while a sparse
// address-to-byte map predicts read words, write byte sequences and handshake timing.
module tb_mem_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        ram_clear;

  int vec_count;
  int miscompares;

  mem_ctrl_if bif();

  mem_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bif.slave),
    .mem_a    (mem_a),
    .mem_wr   (mem_wr),
    .mem_dout (mem_dout),
    .mem_din  (mem_din)
  );

  always #5 clk = ~clk;

  // Bytes never written read back as a fixed function of their address.
  function automatic logic [7:0] bg(input logic [31:0] a);
    return a[7:0] ^ {a[31:28], a[15:12]} ^ 8'h5A;
  endfunction

  function automatic logic [9:0] ram_idx(input logic [31:0] a);
    return {a[31], a[12], a[7:0]};
  endfunction

  logic [7:0] ram     [0:1023];
  logic       ram_vld [0:1023];

  // Synchronous RAM: read data appears the cycle after the address was presented.
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 1024; i++) ram_vld[i] <= 1'b0;
    end else if (mem_wr) begin
      ram[ram_idx(mem_a)]     <= mem_dout;
      ram_vld[ram_idx(mem_a)] <= 1'b1;
    end
    mem_din <= ram_vld[ram_idx(mem_a)] ? ram[ram_idx(mem_a)] : bg(mem_a);
  end

  logic [7:0]  ref_mem [logic [31:0]];
  logic [31:0] last_i;
  logic [31:0] last_d;

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : bg(a);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < n; k++) w = w | (32'(ref_rd(a + 32'(k))) << (8 * k));
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic dropRequests();
    bif.i_read  = 1'b0;
    bif.d_read  = 1'b0;
    bif.d_write = 1'b0;
  endtask

  // kind: 0 I read, 1 D read, 2 D write, 3 D read+write, 4 I and D read together
  task automatic applyStimulus(input int kind, input logic [31:0] addr, input logic [1:0] len,
                               input logic [31:0] wdata, input bit noise);
    int          edges;
    int          n;
    bit          got, is_d, is_wr, busy_low, busy_split, wrong_rdy;
    logic [31:0] exp_rd;
    logic [31:0] wa_q[$];
    logic [7:0]  wb_q[$];

    is_d   = (kind != 0);
    is_wr  = (kind == 2) || (kind == 3);
    n      = is_d ? int'(len) + 1 : 4;
    exp_rd = ref_word(addr, n);

    @(negedge clk);
    bif.i_read  = (kind == 0) || (kind == 4);
    bif.d_read  = (kind == 1) || (kind == 3) || (kind == 4);
    bif.d_write = is_wr;
    bif.i_addr  = addr;
    bif.d_addr  = addr;
    bif.d_len   = len;
    bif.d_wdata = wdata;

    @(posedge clk);
    edges = 0; got = 0; busy_low = 0; busy_split = 0; wrong_rdy = 0;
    while (!got && edges <= 12) begin
      @(negedge clk);
      if (mem_wr) begin
        wa_q.push_back(mem_a);
        wb_q.push_back(mem_dout);
      end
      if (!bif.i_busy) busy_low = 1;
      if (bif.i_busy !== bif.d_busy) busy_split = 1;
      if (is_d ? bif.i_ready : bif.d_ready) wrong_rdy = 1;
      got = is_d ? bif.d_ready : bif.i_ready;
      if (!got) begin
        if (noise) begin
          bif.i_read  = 1'($urandom_range(0, 1));
          bif.d_read  = 1'($urandom_range(0, 1));
          bif.d_write = 1'($urandom_range(0, 1));
          bif.i_addr  = $urandom;
          bif.d_addr  = $urandom;
          bif.d_len   = 2'($urandom_range(0, 3));
          bif.d_wdata = $urandom;
        end
        @(posedge clk);
        edges++;
      end
    end
    dropRequests();

    checkOutput("ready_seen", 32'(got), 32'd1);
    checkOutput("latency", 32'(edges), is_wr ? 32'(n) : 32'(n + 1));
    checkOutput("busy_held", 32'(busy_low), 32'd0);
    checkOutput("busy_equal", 32'(busy_split), 32'd0);
    checkOutput("other_ready", 32'(wrong_rdy), 32'd0);

    if (is_wr) begin
      checkOutput("wr_count", 32'(wa_q.size()), 32'(n));
      for (int k = 0; k < n && k < wa_q.size(); k++) begin
        checkOutput("wr_addr", wa_q[k], addr + 32'(k));
        checkOutput("wr_byte", 32'(wb_q[k]), 32'(wdata[8 * k +: 8]));
      end
      for (int k = 0; k < n; k++) ref_mem[addr + 32'(k)] = wdata[8 * k +: 8];
      checkOutput("d_rdata_hold", bif.d_rdata, last_d);
      checkOutput("i_data_hold", bif.i_data, last_i);
    end else begin
      checkOutput("wr_in_read", 32'(wa_q.size()), 32'd0);
      if (is_d) begin
        checkOutput("d_rdata", bif.d_rdata, exp_rd);
        checkOutput("i_data_hold", bif.i_data, last_i);
        last_d = exp_rd;
      end else begin
        checkOutput("i_data", bif.i_data, exp_rd);
        checkOutput("d_rdata_hold", bif.d_rdata, last_d);
        last_i = exp_rd;
      end
    end

    @(posedge clk);
    @(negedge clk);
    checkOutput("ready_clear", {30'd0, bif.i_ready, bif.d_ready}, 32'd0);
    checkOutput("busy_clear", 32'(bif.i_busy), 32'd0);
  endtask

  function automatic logic [31:0] randAddr();
    case ($urandom_range(0, 2))
      0:       return 32'($urandom_range(0, 240));
      1:       return 32'h0000_1000 + 32'($urandom_range(0, 240));
      default: return 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic resetMidWrite(input logic [31:0] addr, input logic [31:0] wdata);
    bit saw_ready;
    @(negedge clk);
    bif.d_write = 1'b1;
    bif.d_addr  = addr;
    bif.d_len   = 2'd3;
    bif.d_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    dropRequests();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mem_wr", 32'(mem_wr), 32'd0);
    checkOutput("rst_busy", 32'(bif.d_busy), 32'd0);
    checkOutput("rst_ready", {30'd0, bif.i_ready, bif.d_ready}, 32'd0);
    checkOutput("rst_mem_a", mem_a, 32'd0);
    checkOutput("rst_rdata", bif.d_rdata, 32'd0);
    reset = 1'b0;
    saw_ready = 0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      if (bif.i_ready || bif.d_ready || mem_wr) saw_ready = 1;
    end
    checkOutput("rst_no_ready", 32'(saw_ready), 32'd0);
    ref_mem[addr]         = wdata[7:0];
    ref_mem[addr + 32'd1] = wdata[15:8];
    last_i = '0;
    last_d = '0;
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    ram_clear = 1'b1;
    vec_count = 0;
    miscompares = 0;
    last_i = '0;
    last_d = '0;
    dropRequests();
    bif.i_addr = '0;
    bif.d_addr = '0;
    bif.d_len = '0;
    bif.d_wdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", {30'd0, bif.i_busy, bif.d_busy}, 32'd0);
    checkOutput("reset_ready", {30'd0, bif.i_ready, bif.d_ready}, 32'd0);
    checkOutput("reset_mem_a", mem_a, 32'd0);
    checkOutput("reset_mem_wr", 32'(mem_wr), 32'd0);
    checkOutput("reset_mem_dout", 32'(mem_dout), 32'd0);
    checkOutput("reset_i_data", bif.i_data, 32'd0);
    checkOutput("reset_d_rdata", bif.d_rdata, 32'd0);
    reset = 1'b0;
    ram_clear = 1'b0;

    $display("[TB] directed transactions");
    applyStimulus(2, 32'h0000_1000, 2'd3, 32'h9300_0013, 1'b0);
    applyStimulus(0, 32'h0000_1000, 2'd3, 32'h0, 1'b0);
    checkOutput("t1_word", bif.i_data, 32'h9300_0013);

    applyStimulus(2, 32'h0000_0021, 2'd0, 32'h0000_007F, 1'b0);
    applyStimulus(2, 32'h0000_0020, 2'd0, 32'hAABB_CCDD, 1'b0);
    applyStimulus(1, 32'h0000_0020, 2'd1, 32'h0, 1'b0);
    checkOutput("t2_half", bif.d_rdata, 32'h0000_7FDD);

    applyStimulus(4, 32'h0000_1000, 2'd3, 32'h0, 1'b0);
    applyStimulus(0, 32'h0000_0020, 2'd3, 32'h0, 1'b0);

    applyStimulus(2, 32'hFFFF_FFFE, 2'd3, 32'h1122_3344, 1'b0);
    applyStimulus(1, 32'hFFFF_FFFE, 2'd3, 32'h0, 1'b0);
    checkOutput("t4_wrap", bif.d_rdata, 32'h1122_3344);

    applyStimulus(3, 32'h0000_0080, 2'd3, 32'hCAFE_F00D, 1'b1);

    $display("[TB] reset during word write");
    resetMidWrite(32'h0000_0040, 32'h8877_6655);
    applyStimulus(0, 32'h0000_0040, 2'd3, 32'h0, 1'b0);

    $display("[TB] random transactions");
    for (int t = 0; t < 150; t++) begin
      applyStimulus($urandom_range(0, 4), randAddr(), 2'($urandom_range(0, 3)),
                    $urandom, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
